// File: rtl/fft_frame_ctrl.sv
// Frame controller for the 16-point FFT chain: collects samples into frames, holds
// them on frame_x for SETTLE_CYC cycles, then captures and presents the result.
// Define FFT_FRAME_CTRL_BITREV_EN to restore natural bin order at capture.
module fft_frame_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fir_valid,
    input  logic [15:0]  fir_d,
    input  logic         fir_last,
    output logic         fir_ready,
    output logic [255:0] frame_x,
    input  logic [511:0] fft_y,
    output logic         fft_valid,
    input  logic         fft_ready,
    output logic [511:0] fft_d,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, SETTLE} state_e;

    state_e       state_q;
    logic [3:0]   col_cnt_q;
    logic [3:0]   settle_cnt_q;
    logic         col_full_q;
    logic         col_last_q;
    logic         eng_last_q;
    logic         out_last_q;
    logic         fft_valid_q;
    logic         done_q;
    logic [255:0] frame_x_q;
    logic [511:0] fft_d_q;
    logic [15:0]  samp_q [16];

    logic         sample_acc;
    logic         out_acc;
    logic         out_free;
    logic [511:0] cap_y;

    assign sample_acc = fir_valid && !col_full_q;
    assign out_acc    = fft_valid_q && fft_ready;
    assign out_free   = !fft_valid_q || fft_ready;

`ifdef FFT_FRAME_CTRL_BITREV_EN
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    always_comb begin
        cap_y = '0;
        for (int k = 0; k < 16; k++) begin
            cap_y[32*k +: 32] = fft_y[32*bitrev4(4'(k)) +: 32];
        end
    end
`else
    assign cap_y = fft_y;
`endif

    // NOTE: the sample buffer is deliberately not reset; zero-fill on fir_last
    // guarantees every slot is written before a frame is transferred.
    always_ff @(posedge clk) begin
        if (sample_acc) begin
            for (int i = 0; i < 16; i++) begin
                if (4'(i) == col_cnt_q) begin
                    samp_q[i] <= fir_d;
                end else if (fir_last && (4'(i) > col_cnt_q)) begin
                    samp_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_cnt_q    <= '0;
            settle_cnt_q <= '0;
            col_full_q   <= 1'b0;
            col_last_q   <= 1'b0;
            eng_last_q   <= 1'b0;
            out_last_q   <= 1'b0;
            fft_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            frame_x_q    <= '0;
            fft_d_q      <= '0;
        end else begin
            // Accept and engine transfer never coincide: one needs col_full low, the other high.
            if (sample_acc) begin
                if (fir_last || (col_cnt_q == 4'd15)) begin
                    col_full_q <= 1'b1;
                    col_cnt_q  <= '0;
                    col_last_q <= fir_last;
                end else begin
                    col_cnt_q <= col_cnt_q + 4'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (col_full_q) begin
                        for (int i = 0; i < 16; i++) begin
                            frame_x_q[16*i +: 16] <= samp_q[i];
                        end
                        col_full_q   <= 1'b0;
                        eng_last_q   <= col_last_q;
                        settle_cnt_q <= 4'(SETTLE_CYC - 1);
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q != 4'd0) begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end else if (out_free) begin
                        fft_d_q    <= cap_y;
                        out_last_q <= eng_last_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A capture in the accept cycle keeps valid high with the new frame.
            if ((state_q == SETTLE) && (settle_cnt_q == 4'd0) && out_free) begin
                fft_valid_q <= 1'b1;
            end else if (out_acc) begin
                fft_valid_q <= 1'b0;
            end

            done_q <= out_acc && out_last_q;
        end
    end

    assign fir_ready = !col_full_q;
    assign frame_x   = frame_x_q;
    assign fft_valid = fft_valid_q;
    assign fft_d     = fft_d_q;
    assign busy      = (state_q == SETTLE);
    assign done      = done_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed timing cases plus randomized streams checked
// against a frame-level model of the sample stream and a synthetic FFT chain.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         fir_valid = 1'b0;
    logic [15:0]  fir_d = '0;
    logic         fir_last = 1'b0;
    logic         fft_ready = 1'b0;
    logic         fir_ready;
    logic         fft_valid;
    logic         busy;
    logic         done;
    logic [255:0] frame_x;
    logic [511:0] fft_y;
    logic [511:0] fft_d;

    fft_frame_ctrl #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .fir_valid(fir_valid), .fir_d(fir_d), .fir_last(fir_last), .fir_ready(fir_ready),
        .frame_x(frame_x), .fft_y(fft_y),
        .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_d(fft_d),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [255:0] x;
    } frame_t;

    int           n_checks = 0;
    int           n_errors = 0;
    frame_t       exp_q[$];
    logic [255:0] cur_x = '0;
    int           cur_n = 0;
    logic         exp_done_nxt = 1'b0;
    bit           rnd_stop = 1'b0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synthetic last-layer output: element j carries its source sample and its own index.
    function automatic logic [31:0] y_elem(input logic [255:0] x, input int j);
        logic [15:0] s;
        s = x[16*j +: 16];
        return {s, s ^ 16'h5A5A ^ 16'(j)};
    endfunction

    function automatic int src_of(input int k);
`ifdef FFT_FRAME_CTRL_BITREV_EN
        return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
        return k;
`endif
    endfunction

    function automatic logic [511:0] exp_out(input logic [255:0] x);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = y_elem(x, src_of(k));
        return r;
    endfunction

    always_comb begin
        fft_y = '0;
        for (int j = 0; j < 16; j++) fft_y[32*j +: 32] = y_elem(frame_x, j);
    end

    task automatic model_accept(input logic [15:0] d, input logic last);
        frame_t f;
        cur_x[16*cur_n +: 16] = d;
        cur_n++;
        if (last || cur_n == 16) begin
            f.last = last;
            f.x    = cur_x;
            exp_q.push_back(f);
            cur_x = '0;
            cur_n = 0;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        cur_x = '0;
        cur_n = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        fir_valid = 1'b1;
        fir_d     = d;
        fir_last  = last;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = fir_ready;
            @(posedge clk);
        end
        check("send_accept", acc, 1'b1);
        if (acc) model_accept(d, last);
        #1;
        fir_valid = 1'b0;
        fir_last  = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_fir_ready"}, fir_ready, 1'b1);
        check({tag, "_fft_valid"}, fft_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_frame_x"}, frame_x, '0);
        check({tag, "_fft_d"}, fft_d, '0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done_nxt = 1'b0;
            end else begin
                check("done", done, exp_done_nxt);
                exp_done_nxt = 1'b0;
                if (fft_valid && fft_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_frame", fft_valid, 1'b0);
                    end else begin
                        f = exp_q.pop_front();
                        check("fft_d", fft_d, exp_out(f.x));
                        exp_done_nxt = f.last;
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [255:0] px;
        logic [255:0] f2;
        int           left;

        fork monitor(); join_none

        #2 rst_n = 1'b0;
        #1 reset_checks("por");
        tick(2);
        rst_n = 1'b1;

        // Single full frame: exact latency and one-cycle done.
        fft_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(16'h0100, i == 15);
        check("ready_low_E0", fir_ready, 1'b0);
        tick(1);
        check("frame_x_E1", frame_x, {16{16'h0100}});
        check("busy_E1", busy, 1'b1);
        check("ready_E1", fir_ready, 1'b1);
        repeat (SETTLE - 1) begin
            tick(1);
            check("valid_early", fft_valid, 1'b0);
        end
        tick(1);
        check("valid_capture", fft_valid, 1'b1);
        check("bin1", fft_d[63:32], y_elem({16{16'h0100}}, src_of(1)));
        check("bin3", fft_d[127:96], y_elem({16{16'h0100}}, src_of(3)));
        tick(1);
        check("valid_after_accept", fft_valid, 1'b0);
        check("done_pulse", done, 1'b1);
        tick(1);
        check("done_low", done, 1'b0);
        check("busy_idle", busy, 1'b0);

        // Partial frame: zero fill above the last slot.
        for (int i = 0; i < 5; i++) send(16'h0200, i == 4);
        tick(1);
        px = '0;
        for (int i = 0; i < 5; i++) px[16*i +: 16] = 16'h0200;
        check("partial_frame_x", frame_x, px);
        tick(8);

        // Backpressure over three frames, then release exactly at the held capture.
        fft_ready = 1'b0;
        for (int i = 0; i < 48; i++) send(16'(i), 1'b0);
        tick(10);
        f2 = '0;
        for (int i = 0; i < 16; i++) f2[16*i +: 16] = 16'(16 + i);
        check("bp_ready_low", fir_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_valid", fft_valid, 1'b1);
        check("bp_frame_x", frame_x, f2);
        fft_ready = 1'b1;
        tick(1);
        check("same_cycle_valid", fft_valid, 1'b1);
        check("same_cycle_data", fft_d, exp_out(f2));
        tick(30);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(16'($urandom), 1'b0);
        #3 rst_n = 1'b0;
        #1 reset_checks("mid");
        model_flush();
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(16'(1000 + i), 1'b0);
        tick(10);

        // Randomized streams with random gaps and random consumer stalls.
        fork
            while (!rnd_stop) begin
                @(posedge clk);
                #1;
                if (!rnd_stop) fft_ready = ($urandom_range(3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(2));
            send(16'($urandom), (i == 299) || ($urandom_range(11) == 0));
        end
        @(negedge clk);
        rnd_stop  = 1'b1;
        fft_ready = 1'b1;
        left = 200;
        while (exp_q.size() != 0 && left > 0) begin
            tick(1);
            left--;
        end
        check("final_drain", 32'(exp_q.size()), 32'd0);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
